event_rate_counter: RTL and testbench

//  Counts single-cycle event strobes over a programmable gate window of clk

---
 rtl/event_rate_counter.sv | 106 ++++++++++
 tb/tb_event_rate_counter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/event_rate_counter.sv
// rtl/event_rate_counter.sv - gated event counter with held per-window totals
// Back-to-back windows of max(gate_len,1) COUNT cycles; totals saturate at all-ones.
module event_rate_counter #(
  parameter int WIDTH      = 32,
  parameter int GATE_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  event_i,
  input  logic [GATE_WIDTH-1:0] gate_len,
  output logic [WIDTH-1:0]      count_o,
  output logic                  count_valid,
  output logic                  overflow,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT} state_t;

  localparam logic [WIDTH-1:0] ONES = '1;

  state_t                state_q, state_d;
  logic [GATE_WIDTH-1:0] gate_q, gate_d;
  logic [WIDTH-1:0]      acc_q, acc_d;
  logic                  sat_q, sat_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  valid_q, valid_d;
  logic                  ovf_q, ovf_d;

  logic [GATE_WIDTH-1:0] gate_load;
  logic [WIDTH-1:0]      acc_sum;
  logic                  drop;

  assign gate_load = (gate_len == '0) ? GATE_WIDTH'(1) : gate_len;
  // Saturation means an event arrived while the accumulator was already full.
  assign drop      = (acc_q == ONES) && event_i;
  assign acc_sum   = (acc_q == ONES) ? ONES : acc_q + WIDTH'(event_i);

  always_comb begin
    state_d = state_q;
    gate_d  = gate_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_ARM;
      end
      S_ARM: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          gate_d  = gate_load;
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (gate_q == GATE_WIDTH'(1)) begin
          count_d = acc_sum;
          ovf_d   = sat_q | drop;
          valid_d = 1'b1;
          acc_d   = '0;
          sat_d   = 1'b0;
          gate_d  = gate_load;
        end else begin
          acc_d  = acc_sum;
          sat_d  = sat_q | drop;
          gate_d = gate_q - GATE_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gate_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gate_q  <= gate_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o     = count_q;
  assign count_valid = valid_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_event_rate_counter.sv
// tb/tb_event_rate_counter.sv - randomized and directed bench for event_rate_counter
// A cycle-level reference model with unbounded tallies is compared on every negedge.
module tb_event_rate_counter;

  localparam int W  = 4;
  localparam int GW = 8;
  localparam int MAXC = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          event_i;
  logic [GW-1:0] gate_len;
  logic [W-1:0]  count_o;
  logic          count_valid;
  logic          overflow;
  logic          busy;

  int tests = 0;
  int fails = 0;

  event_rate_counter #(.WIDTH(W), .GATE_WIDTH(GW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .event_i(event_i), .gate_len(gate_len),
    .count_o(count_o), .count_valid(count_valid), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: phase 0 idle, 1 arming, 2 counting; tally kept as a plain integer.
  int m_phase = 0;
  int m_left  = 0;
  int m_tally = 0;
  int e_count = 0;
  int e_ovf   = 0;
  int e_valid = 0;

  function automatic int win_len(input int g);
    return (g == 0) ? 1 : g;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_tally = 0; e_count = 0; e_ovf = 0; e_valid = 0;
    end else begin
      e_valid = 0;
      if (!enable) begin
        m_phase = 0;
      end else if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_left = win_len(int'(gate_len)); m_tally = 0; m_phase = 2;
      end else begin
        m_tally += int'(event_i);
        m_left--;
        if (m_left == 0) begin
          e_count = (m_tally > MAXC) ? MAXC : m_tally;
          e_ovf   = (m_tally > MAXC) ? 1 : 0;
          e_valid = 1;
          m_tally = 0;
          m_left  = win_len(int'(gate_len));
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit model_on = 1'b0;
  always @(negedge clk) begin
    if (model_on) begin
      check("model_count", int'(count_o), e_count);
      check("model_valid", int'(count_valid), e_valid);
      check("model_ovf", int'(overflow), e_ovf);
      check("model_busy", int'(busy), (m_phase != 0) ? 1 : 0);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_valid(input int bound, input string name);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (count_valid) return;
    end
    check({name, "_timeout"}, 0, 1);
  endtask

  task automatic restart(input int g, input logic ev);
    enable = 1'b0;
    tick(); tick();
    gate_len = GW'(g);
    event_i  = ev;
    enable   = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; event_i = 1'b0; gate_len = GW'(10);
    model_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_count", int'(count_o), 0);
      check("reset_valid", int'(count_valid), 0);
      check("reset_ovf", int'(overflow), 0);
      check("reset_busy", int'(busy), 0);
    end

    // Basic window: ARM at edge 2, COUNT edges 3..12, four events on edges 4..7.
    rst = 1'b0;
    for (int i = 1; i <= 22; i++) begin
      event_i = (i >= 4 && i <= 7);
      tick();
      check("basic_pulse", int'(count_valid), (i == 12 || i == 22) ? 1 : 0);
      if (i == 12) check("basic_count", int'(count_o), 4);
      if (i == 22) check("basic_count2", int'(count_o), 0);
    end

    // gate_len 0: every COUNT cycle closes a one-cycle window.
    restart(0, 1'b1);
    wait_valid(10, "g0");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("g0_valid", int'(count_valid), 1);
      check("g0_count", int'(count_o), 1);
    end

    // Terminal-cycle event belongs to the closing window.
    restart(5, 1'b1);
    for (int i = 0; i < 3; i++) begin
      wait_valid(12, "g5");
      check("g5_count", int'(count_o), 5);
    end

    restart(20, 1'b1);
    wait_valid(30, "sat");
    check("sat_count", int'(count_o), 15);
    check("sat_ovf", int'(overflow), 1);
    repeat (3) tick();
    event_i = 1'b0;
    wait_valid(30, "after_sat");
    check("after_sat_count", int'(count_o), 3);
    check("after_sat_ovf", int'(overflow), 0);

    // Abort on cycle 6 of a 10-cycle window.
    restart(10, 1'b1);
    begin
      int seen = 0;
      for (int i = 0; i < 7; i++) begin tick(); seen += int'(count_valid); end
      enable = 1'b0;
      for (int i = 0; i < 3; i++) begin tick(); seen += int'(count_valid); end
      check("abort_no_valid", seen, 0);
      check("abort_count_held", int'(count_o), 3);
      check("abort_busy", int'(busy), 0);
    end
    enable = 1'b1;
    wait_valid(20, "rearm");
    check("rearm_count", int'(count_o), 10);

    // Reset pulse mid-window.
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check("midrst_count", int'(count_o), 0);
    check("midrst_valid", int'(count_valid), 0);
    check("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    wait_valid(20, "post_rst");
    check("post_rst_count", int'(count_o), 10);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      event_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 30) == 0) gate_len = GW'($urandom_range(0, 24));
      enable = ($urandom_range(0, 60) != 0);
      rst    = ($urandom_range(0, 400) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
